sort_feeder: RTL and testbench

- Frame-level front end for the toggle-commanded insertion sorter.
- Accepts one frame of words on a valid/ready input stream and issues clear/push/sort/pop toggle commands to the sorter.
- Waits on the sorter's idle flag after every command, then drains the sorted result onto a valid/ready output stream with last marking.
- Sits directly upstream and downstream of the sorter; the sorter's enable is tied high.

---
 rtl/sort_feeder.sv | 211 +++++++++++++++++++++
 tb/tb_sort_feeder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_feeder.sv
// Frame front end for the toggle-commanded insertion sorter: loads one frame,
// sorts it, then drains it largest-first onto a valid/ready stream.
module sort_feeder #(
  parameter int W       = 16,
  parameter int MAX_LEN = 255,
  parameter int TO_W    = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  output logic         m_last,
  input  logic         m_ready,
  output logic         srt_clear,
  output logic         srt_push,
  output logic         srt_sort,
  output logic         srt_pop,
  output logic [W-1:0] srt_din,
  input  logic [W-1:0] srt_dout,
  input  logic         srt_idle,
  output logic         busy,
  output logic         overflow,
  output logic         err
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_IN    = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  // Command code doubles as the toggle bit index (bit0 clear .. bit3 pop).
  localparam logic [1:0] P_CLR  = 2'd0;
  localparam logic [1:0] P_PUSH = 2'd1;
  localparam logic [1:0] P_SORT = 2'd2;
  localparam logic [1:0] P_POP  = 2'd3;

  logic [2:0]      state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [3:0]      tog_q, tog_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [W-1:0]    din_q, din_d;
  logic [W-1:0]    mdata_q, mdata_d;
  logic            mvalid_q, mvalid_d;
  logic            mlast_q, mlast_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic            issue;
  logic [1:0]      cmd;

  always_comb begin
    // NOTE: every next-state value starts from its register so no path leaves it unassigned (no latch).
    state_d  = state_q;
    phase_d  = phase_q;
    tog_d    = tog_q;
    count_d  = count_q;
    rem_d    = rem_q;
    last_d   = last_q;
    wd_d     = wd_q;
    din_d    = din_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    mlast_d  = mlast_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    issue    = 1'b0;
    cmd      = P_CLR;

    case (state_q)
      S_IDLE: begin
        if (srt_idle) begin
          issue = 1'b1;
          cmd   = P_CLR;
        end
      end
      S_IN: begin
        if (s_valid) begin
          last_d = s_last;
          if (count_q == CW'(MAX_LEN)) begin
            ovf_d = 1'b1;
            if (s_last) begin
              issue = 1'b1;
              cmd   = P_SORT;
            end
          end else begin
            din_d   = s_data;
            count_d = count_q + 1'b1;
            issue   = 1'b1;
            cmd     = P_PUSH;
          end
        end
      end
      // The sorter has not yet seen the new toggle, so its idle flag is stale here.
      S_GUARD: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (srt_idle) begin
          case (phase_q)
            P_CLR:  state_d = S_IN;
            P_PUSH: begin
              if (last_q) begin
                issue = 1'b1;
                cmd   = P_SORT;
              end else begin
                state_d = S_IN;
              end
            end
            P_SORT: begin
              rem_d = count_q;
              issue = 1'b1;
              cmd   = P_POP;
            end
            default: begin
              mdata_d  = srt_dout;
              mvalid_d = 1'b1;
              mlast_d  = (rem_q == CW'(1));
              rem_d    = rem_q - 1'b1;
              state_d  = S_OUT;
            end
          endcase
        end else if (wd_q == TO_MAX) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_OUT: begin
        if (m_ready) begin
          mvalid_d = 1'b0;
          mlast_d  = 1'b0;
          if (mlast_q) begin
            count_d = '0;
            state_d = S_IDLE;
          end else begin
            issue = 1'b1;
            cmd   = P_POP;
          end
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      tog_d   = tog_q ^ (4'b0001 << cmd);
      phase_d = cmd;
      state_d = S_GUARD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= P_CLR;
      tog_q    <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      last_q   <= 1'b0;
      wd_q     <= '0;
      din_q    <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      phase_q  <= phase_d;
      tog_q    <= tog_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      last_q   <= last_d;
      wd_q     <= wd_d;
      din_q    <= din_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign s_ready   = (state_q == S_IN);
  assign busy      = (state_q != S_IDLE);
  assign m_data    = mdata_q;
  assign m_valid   = mvalid_q;
  assign m_last    = mlast_q;
  assign srt_clear = tog_q[0];
  assign srt_push  = tog_q[1];
  assign srt_sort  = tog_q[2];
  assign srt_pop   = tog_q[3];
  assign srt_din   = din_q;
  assign overflow  = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sort_feeder.sv
// Scoreboard bench for sort_feeder: a behavioural toggle sorter answers commands,
// directed frames push hand-computed outputs, a monitor pops and compares.
module tb_sort_feeder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic [W-1:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic m_ready = 1'b1;
  logic [W-1:0] srt_dout = '0;
  logic m_idle;
  logic hang_en = 1'b0;

  logic [W-1:0] m_data0, m_data1, srt_din0, srt_din1;
  logic s_ready0, s_ready1, m_valid0, m_valid1, m_last0, m_last1;
  logic clr0, clr1, psh0, psh1, srt0, srt1, pop0, pop1;
  logic busy0, busy1, ovf0, ovf1, err0, err1;

  always #5 clk = ~clk;

  sort_feeder dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready0), .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0),
    .m_ready(m_ready), .srt_clear(clr0), .srt_push(psh0), .srt_sort(srt0),
    .srt_pop(pop0), .srt_din(srt_din0), .srt_dout(srt_dout),
    .srt_idle(m_idle & ~sel), .busy(busy0), .overflow(ovf0), .err(err0)
  );

  sort_feeder #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready1), .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1),
    .m_ready(m_ready), .srt_clear(clr1), .srt_push(psh1), .srt_sort(srt1),
    .srt_pop(pop1), .srt_din(srt_din1), .srt_dout(srt_dout),
    .srt_idle(m_idle & sel), .busy(busy1), .overflow(ovf1), .err(err1)
  );

  wire [W-1:0] m_data_m  = sel ? m_data1 : m_data0;
  wire [W-1:0] srt_din_m = sel ? srt_din1 : srt_din0;
  wire s_ready_m = sel ? s_ready1 : s_ready0;
  wire m_valid_m = sel ? m_valid1 : m_valid0;
  wire m_last_m  = sel ? m_last1 : m_last0;
  wire busy_m    = sel ? busy1 : busy0;
  wire ovf_m     = sel ? ovf1 : ovf0;
  wire err_m     = sel ? err1 : err0;
  wire [3:0] tog_m = sel ? {pop1, srt1, psh1, clr1} : {pop0, srt0, psh0, clr0};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_s(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Behavioural sorter: any toggle edge makes it busy for a few cycles, then it acts.
  logic [W-1:0] q[$];
  logic [W-1:0] tmp;
  logic [3:0] prev = '0;
  logic [3:0] pend = '0;
  int busy_cnt = 0;
  int n_pop = 0;
  int cyc = 0;
  int pop_done_cyc = 0;
  string ops = "";
  wire [3:0] diff = tog_m ^ prev;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      m_idle   <= 1'b1;
      busy_cnt <= 0;
      srt_dout <= '0;
      q.delete();
    end else if (diff != 4'b0) begin
      check("cmd_onehot", $countones(diff), 1);
      prev   <= tog_m;
      pend   <= diff;
      m_idle <= 1'b0;
      busy_cnt <= (hang_en && diff[1]) ? 100000 : 3;
      if (diff[0]) ops = {ops, "C"};
      if (diff[1]) ops = {ops, "P"};
      if (diff[2]) ops = {ops, "S"};
      if (diff[3]) begin
        ops = {ops, "O"};
        n_pop = n_pop + 1;
      end
    end else if (!m_idle) begin
      if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end else begin
        m_idle <= 1'b1;
        if (pend[0]) q.delete();
        if (pend[1]) q.push_back(srt_din_m);
        if (pend[2]) begin
          for (int i = 0; i < q.size(); i++)
            for (int j = 0; j + 1 < q.size() - i; j++)
              if (q[j] > q[j+1]) begin
                tmp = q[j]; q[j] = q[j+1]; q[j+1] = tmp;
              end
        end
        if (pend[3]) begin
          srt_dout <= q[$];
          q.pop_back();
          pop_done_cyc <= cyc + 1;
        end
      end
    end
  end

  typedef struct {logic [W-1:0] d; logic l;} exp_t;
  exp_t sb[$];

  task automatic expect_out(input logic [W-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_valid_m && m_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h with nothing expected", m_data_m);
        end else begin
          e = sb.pop_front();
          check("out_data", m_data_m, e.d);
          check("out_last", m_last_m, e.l);
        end
      end
    end
  end

  task automatic do_reset(input logic s);
    rst = 1'b1;
    sel = s;
    repeat (3) @(posedge clk);
    #1;
    ops = "";
    check("rst_s_ready", s_ready_m, 0);
    check("rst_m_valid", m_valid_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_toggles", tog_m, 0);
    check("rst_overflow", ovf_m, 0);
    check("rst_err", err_m, 0);
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic l);
    int t = 0;
    s_data = d;
    s_valid = 1'b1;
    s_last = l;
    forever begin
      @(negedge clk);
      if (s_ready_m) break;
      t++;
      if (t > 2000) begin
        check("s_ready_timeout", s_ready_m, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 3000) begin
        check("drain_timeout", sb.size(), 0);
        sb.delete();
      end
    end
  endtask

  task automatic wait_mvalid();
    int t = 0;
    while (!m_valid_m) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 2000) begin
        check("m_valid_timeout", m_valid_m, 1);
        break;
      end
    end
  endtask

  initial begin
    int pops_before;
    int t;

    do_reset(1'b0);

    // Frame 5,1,4,2,3 -> descending output, busy falls on the final handshake.
    expect_out(16'd5, 0); expect_out(16'd4, 0); expect_out(16'd3, 0);
    expect_out(16'd2, 0); expect_out(16'd1, 1);
    send_word(16'd5, 0); send_word(16'd1, 0); send_word(16'd4, 0);
    send_word(16'd2, 0); send_word(16'd3, 1);
    wait_drain();
    check("f1_busy_after", busy_m, 0);
    check_s("f1_ops", ops, "CPPPPPSOOOOO");
    ops = "";

    // Single-word frame; output appears one cycle after the pop completes.
    expect_out(16'h00AA, 1);
    send_word(16'h00AA, 1);
    wait_mvalid();
    check("f2_latency", cyc - pop_done_cyc, 1);
    wait_drain();
    check_s("f2_ops", ops, "CPSO");

    // Frame 3,9,7 with back-pressure on the second output word.
    expect_out(16'd9, 0); expect_out(16'd7, 0); expect_out(16'd3, 1);
    m_ready = 1'b0;
    send_word(16'd3, 0); send_word(16'd9, 0); send_word(16'd7, 1);
    wait_mvalid();
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    wait_mvalid();
    pops_before = n_pop;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", m_valid_m, 1);
      check("hold_data", m_data_m, 16'd7);
      check("hold_no_pop", n_pop, pops_before);
    end
    m_ready = 1'b1;
    wait_drain();

    // MAX_LEN=4 instance: six words, last two dropped.
    do_reset(1'b1);
    expect_out(16'd40, 0); expect_out(16'd30, 0); expect_out(16'd20, 0); expect_out(16'd10, 1);
    send_word(16'd10, 0); send_word(16'd20, 0); send_word(16'd30, 0);
    send_word(16'd40, 0); send_word(16'd50, 0); send_word(16'd60, 1);
    wait_drain();
    check("ovf_set", ovf_m, 1);
    check_s("ovf_ops", ops, "CPPPPSOOOO");

    // Sorter stalls after a push -> watchdog error.
    do_reset(1'b0);
    hang_en = 1'b1;
    send_word(16'h0055, 0);
    t = 0;
    while (!err_m && t < 6000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("err_set", err_m, 1);
    check("err_s_ready", s_ready_m, 0);
    check("err_m_valid", m_valid_m, 0);
    check("err_busy", busy_m, 1);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", err_m, 1);
    hang_en = 1'b0;
    do_reset(1'b0);

    // Back-to-back frames, each preceded by its own clear.
    expect_out(16'd2, 0); expect_out(16'd1, 1);
    send_word(16'd2, 0); send_word(16'd1, 1);
    wait_drain();
    check_s("b2b1_ops", ops, "CPPSOO");
    ops = "";
    expect_out(16'd8, 0); expect_out(16'd7, 0); expect_out(16'd6, 1);
    send_word(16'd7, 0); send_word(16'd8, 0); send_word(16'd6, 1);
    wait_drain();
    check_s("b2b2_ops", ops, "CPPPSOOO");
    check("b2b_overflow", ovf_m, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
